pair_stim_checker: RTL and testbench

Self-checking traffic source and sink for the two-input registered XOR-sum datapath in the test designs. It generates a pseudo-random bit pair on `dina`/`dinb` from an LFSR and predicts the datapath result (`dina + dinb` truncated to 1 bit). It then compares the returned `dout` against that prediction after a fixed pipeline latency, and reports an error count and a pass/fail verdict. It sits on the far side of the datapath, driving its inputs and consuming its output.

---
 rtl/pair_stim_checker.sv | 126 ++++++++++++
 tb/tb_pair_stim_checker.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pair_stim_checker.sv
// LFSR-driven stimulus source and result checker for a LAT-stage registered XOR datapath.
// Drives dina/dinb, predicts dina^dinb, compares dout_in LAT cycles later, and counts mismatches.
module pair_stim_checker #(
  parameter logic [15:0] SEED    = 16'hACE1,
  parameter int          NUM_VEC = 256,
  parameter int          LAT     = 3,
  parameter int          CNT_W   = 16
) (
  input  logic             clki,
  input  logic             rst,
  input  logic             start,
  output logic             dina,
  output logic             dinb,
  input  logic             dout_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_cnt,
  output logic [1:0]       dbg_state
);

  localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [15:0]      lfsr;
  logic [15:0]      vec_cnt;
  logic [3:0]       flush_cnt;
  logic [LAT-1:0]   exp_d;
  logic [LAT-1:0]   exp_v;
  logic             start_acc;
  logic             last_vec;
  logic             last_flush;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  assign start_acc  = ((state == S_IDLE) || (state == S_DONE)) && start;
  assign last_vec   = (vec_cnt == 16'(NUM_VEC));
  assign last_flush = (flush_cnt == 4'(LAT - 1));

  always_ff @(posedge clki or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_RUN;
      S_RUN:   if (last_vec) state_nxt = S_FLUSH;
      S_FLUSH: if (last_flush) state_nxt = S_DONE;
      S_DONE:  if (start) state_nxt = S_RUN;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state == S_RUN) || (state == S_FLUSH);
    done      = (state == S_DONE);
    pass      = done && (err_cnt == '0);
    dbg_state = state;
  end

  // The expect pipeline captures the vector currently on dina/dinb, so its
  // last stage lines up with dout_in sampled LAT edges after that vector.
  always_ff @(posedge clki or posedge rst) begin
    if (rst) begin
      lfsr      <= SEED_EFF;
      dina      <= 1'b0;
      dinb      <= 1'b0;
      vec_cnt   <= 16'd0;
      flush_cnt <= 4'd0;
      exp_d     <= '0;
      exp_v     <= '0;
      err_cnt   <= '0;
    end else begin
      for (int i = LAT - 1; i > 0; i--) begin
        exp_d[i] <= exp_d[i-1];
        exp_v[i] <= exp_v[i-1];
      end
      exp_d[0] <= dina ^ dinb;
      exp_v[0] <= (state == S_RUN);

      if (busy && exp_v[LAT-1] && (dout_in != exp_d[LAT-1]) && (err_cnt != '1))
        err_cnt <= err_cnt + CNT_W'(1);

      if (start_acc) begin
        dina      <= SEED_EFF[0];
        dinb      <= SEED_EFF[1];
        lfsr      <= lfsr_next(SEED_EFF);
        vec_cnt   <= 16'd1;
        flush_cnt <= 4'd0;
        exp_v     <= '0;
        err_cnt   <= '0;
      end else if (state == S_RUN) begin
        flush_cnt <= 4'd0;
        if (!last_vec) begin
          dina    <= lfsr[0];
          dinb    <= lfsr[1];
          lfsr    <= lfsr_next(lfsr);
          vec_cnt <= vec_cnt + 16'd1;
        end else begin
          dina <= 1'b0;
          dinb <= 1'b0;
        end
      end else if (state == S_FLUSH) begin
        dina      <= 1'b0;
        dinb      <= 1'b0;
        flush_cnt <= flush_cnt + 4'd1;
      end else begin
        dina <= 1'b0;
        dinb <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pair_stim_checker.sv
// Bench for pair_stim_checker: a 3-register XOR datapath model in loopback, with per-vector
// fault injection, plus a 4-bit-counter instance always fed an inverted result to test saturation.
module tb_pair_stim_checker;

  localparam int          NV   = 256;
  localparam int          LT   = 3;
  localparam logic [15:0] SEED = 16'hACE1;

  logic        clki = 1'b0;
  logic        rst;
  logic        start;
  logic        dina, dinb, dout_in, busy, done, pass;
  logic [15:0] err_cnt;
  logic [1:0]  dbg_state;
  logic        dina_s, dinb_s, dout_s, busy_s, done_s, pass_s;
  logic [3:0]  err_s;
  logic [1:0]  dbg_s;

  int vectors     = 0;
  int miscompares = 0;

  logic [1:0]  vec_q[$];
  logic [15:0] exp_q[$];
  logic [3:0]  exp_s_q[$];

  logic flip[NV];
  logic stuck0;
  logic d1, d2, d3, s1, s2, s3;
  int   pidx;

  // ---------------- clock / reset ----------------
  always #5 clki = ~clki;

  pair_stim_checker #(.SEED(SEED), .NUM_VEC(NV), .LAT(LT), .CNT_W(16)) dut (
    .clki(clki), .rst(rst), .start(start), .dina(dina), .dinb(dinb),
    .dout_in(dout_in), .busy(busy), .done(done), .pass(pass),
    .err_cnt(err_cnt), .dbg_state(dbg_state)
  );

  pair_stim_checker #(.SEED(SEED), .NUM_VEC(NV), .LAT(LT), .CNT_W(4)) dut_s (
    .clki(clki), .rst(rst), .start(start), .dina(dina_s), .dinb(dinb_s),
    .dout_in(dout_s), .busy(busy_s), .done(done_s), .pass(pass_s),
    .err_cnt(err_s), .dbg_state(dbg_s)
  );

  // Datapath under test: three register stages; flip[k] corrupts vector k on its way in.
  always @(posedge clki) begin
    d1   <= dina ^ dinb ^ ((busy && pidx < NV) ? flip[pidx] : 1'b0);
    d2   <= d1;
    d3   <= d2;
    pidx <= busy ? pidx + 1 : 0;
    s1   <= dina_s ^ dinb_s;
    s2   <= s1;
    s3   <= s2;
  end
  assign dout_in = stuck0 ? 1'b0 : d3;
  assign dout_s  = ~s3;

  // ---------------- reference model / driver tasks ----------------
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    logic fb;
    fb = s[15] ^ s[13] ^ s[12] ^ s[10];
    return 16'((s << 1) | 16'(fb));
  endfunction

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_flips(input int kind);
    for (int k = 0; k < NV; k++)
      flip[k] = (kind == 1) ? 1'b1 : (kind == 2) ? ($urandom_range(0, 3) == 0) : 1'b0;
  endtask

  task automatic start_run();
    logic [15:0] s;
    int ones, errs;
    @(negedge clki);
    s = SEED; ones = 0; errs = 0;
    for (int k = 0; k < NV; k++) begin
      vec_q.push_back({s[1], s[0]});
      ones += int'(s[0] ^ s[1]);
      errs += int'(flip[k]);
      s = lfsr_step(s);
    end
    exp_q.push_back(stuck0 ? 16'(ones) : 16'(errs));
    exp_s_q.push_back(4'((NV > 15) ? 15 : NV));
    start = 1'b1;
    @(negedge clki);
    start = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!done && n < 2000) begin
      @(negedge clki);
      n++;
    end
    if (!done) begin
      vectors++;
      miscompares++;
      $display("FAIL done_timeout: got done=0 expected done=1 within 2000 cycles");
    end
    @(negedge clki);
  endtask

  task automatic check_reset();
    check("rst_dina", int'(dina), 0);
    check("rst_dinb", int'(dinb), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_pass", int'(pass), 0);
    check("rst_err", int'(err_cnt), 0);
    check("rst_state", int'(dbg_state), 0);
    check("rst_s_busy", int'(busy_s), 0);
    check("rst_s_err", int'(err_s), 0);
  endtask

  task automatic reset_now();
    rst = 1'b1;
    #1;
    check_reset();
    vec_q.delete();
    exp_q.delete();
    exp_s_q.delete();
    @(negedge clki);
    rst = 1'b0;
  endtask

  // ---------------- scoreboard monitor ----------------
  int   bcyc;
  logic done_q, done_s_q;
  logic [1:0]  v;
  logic [15:0] e;
  logic [3:0]  es;

  always @(negedge clki) begin
    if (rst) begin
      bcyc     = 0;
      done_q   = 1'b0;
      done_s_q = 1'b0;
    end else begin
      if (busy) begin
        if (bcyc < NV) begin
          if (vec_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL vec_underflow: got unexpected vector at busy cycle %0d", bcyc);
          end else begin
            v = vec_q.pop_front();
            check("vector", int'({dinb, dina}), int'(v));
          end
        end else begin
          check("flush_zero", int'({dinb, dina}), 0);
        end
        bcyc++;
      end
      if (done && !done_q) begin
        check("run_len", bcyc, NV + LT);
        bcyc = 0;
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL res_underflow: got done with no expected result");
        end else begin
          e = exp_q.pop_front();
          check("err_cnt", int'(err_cnt), int'(e));
          check("pass", int'(pass), int'(e == 16'd0));
        end
      end
      if (done_s && !done_s_q && exp_s_q.size() != 0) begin
        es = exp_s_q.pop_front();
        check("sat_err_cnt", int'(err_s), int'(es));
        check("sat_pass", int'(pass_s), 0);
      end
      done_q   = done;
      done_s_q = done_s;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst    = 1'b1;
    start  = 1'b0;
    stuck0 = 1'b0;
    set_flips(0);
    repeat (3) @(negedge clki);
    check_reset();
    @(negedge clki);
    rst = 1'b0;

    // reset from a random point inside a run
    start_run();
    repeat ($urandom_range(5, 300)) @(negedge clki);
    reset_now();

    // clean loopback, with an ignored start at RUN cycle 10
    start_run();
    check("first_vec", int'({dinb, dina}), 1);
    repeat (10) @(negedge clki);
    start = 1'b1;
    @(negedge clki);
    start = 1'b0;
    wait_done();

    // inverted result on every vector
    set_flips(1);
    start_run();
    wait_done();

    // result stuck at 0
    set_flips(0);
    stuck0 = 1'b1;
    start_run();
    wait_done();
    stuck0 = 1'b0;

    // random corruption patterns with random idle gaps
    for (int r = 0; r < 3; r++) begin
      set_flips(2);
      repeat ($urandom_range(0, 5)) @(negedge clki);
      start_run();
      wait_done();
    end

    // reset at RUN cycle 100, then an identical rerun
    set_flips(0);
    start_run();
    repeat (99) @(negedge clki);
    reset_now();
    start_run();
    wait_done();

    repeat (3) @(negedge clki);
    check("exp_q_empty", exp_q.size(), 0);
    check("vec_q_empty", vec_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
